// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the MDU sequencer: op encodings, FSM states, default latencies.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage <-> MDU bundle: operation request, operands, result select, busy and result.
interface mdu_ctrl_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        out_sel;
  logic        flush;
  logic        busy;
  logic [31:0] out;

  modport master (
    output start, op, rs, rt, out_sel, flush,
    input  busy, out
  );

  modport slave (
    input  start, op, rs, rt, out_sel, flush,
    output busy, out
  );
endinterface

// File: rtl/mdu_ctrl_arith.sv
// Combinational 64-bit product and 32-bit quotient/remainder, signed or unsigned.
module mdu_arith (
  input  logic        sgn_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [63:0] prod_o,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  logic signed [63:0] a_ext, b_ext, prod_s;
  logic               a_neg, b_neg;
  logic        [31:0] a_mag, b_mag, q_mag, r_mag;

  always_comb begin
    a_ext  = {{32{sgn_i & rs_i[31]}}, rs_i};
    b_ext  = {{32{sgn_i & rt_i[31]}}, rt_i};
    prod_s = a_ext * b_ext;
    prod_o = prod_s;
  end

  // Divide on magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. A zero divisor yields zeros (never committed).
  always_comb begin
    a_neg = sgn_i & rs_i[31];
    b_neg = sgn_i & rt_i[31];
    a_mag = a_neg ? (~rs_i + 32'd1) : rs_i;
    b_mag = b_neg ? (~rt_i + 32'd1) : rt_i;
    q_mag = 32'd0;
    r_mag = 32'd0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quo_o = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem_o = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer holding HI/LO with a registered busy flag.
// Define MDU_FAST_EN to commit mult/div at the accepting edge with busy held low.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);

  mdu_state_e  state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        wr_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_n_q, lo_n_q;

  logic        accept;
  logic        div_zero;
  logic [63:0] prod;
  logic [31:0] quo, rem;
  logic [31:0] out_d;

  mdu_arith u_arith (
    .sgn_i  (op_is_signed(bus.op)),
    .rs_i   (bus.rs),
    .rt_i   (bus.rt),
    .prod_o (prod),
    .quo_o  (quo),
    .rem_o  (rem)
  );

  assign accept   = bus.start & ~bus.flush;
  assign div_zero = (bus.rt == 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_n_q  <= 32'd0;
      lo_n_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (bus.op)
              MDU_MULT, MDU_MULTU: begin
`ifdef MDU_FAST_EN
                {hi_q, lo_q} <= prod;
`else
                {hi_n_q, lo_n_q} <= prod;
                wr_q    <= 1'b1;
                cnt_q   <= 4'(MULT_CYCLES);
                busy_q  <= 1'b1;
                state_q <= S_RUN;
`endif
              end
              MDU_DIV, MDU_DIVU: begin
`ifdef MDU_FAST_EN
                if (!div_zero) begin
                  hi_q <= rem;
                  lo_q <= quo;
                end
`else
                hi_n_q  <= rem;
                lo_n_q  <= quo;
                wr_q    <= ~div_zero;
                cnt_q   <= 4'(DIV_CYCLES);
                busy_q  <= 1'b1;
                state_q <= S_RUN;
`endif
              end
              MDU_MTHI: hi_q <= bus.rs;
              MDU_MTLO: lo_q <= bus.rs;
              default: ;
            endcase
          end
        end
        // Flush and start are deliberately ignored here: the running op is older.
        S_RUN: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            if (wr_q) begin
              hi_q <= hi_n_q;
              lo_q <= lo_n_q;
            end
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_d = bus.out_sel ? lo_q : hi_q;
  end

  assign bus.out  = out_d;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed MDU ops, queued expectations, decoupled monitors.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mdu_ctrl_if bus();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sel;
    logic [31:0] val;
    logic        bsy;
  } item_t;

  item_t sb_q[$];
  int    lat_q[$];
  event  chk_ev;

  // Value monitor: compares out/busy whenever a check is posted.
  initial begin
    item_t it;
    forever begin
      @(chk_ev);
      #1;
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        total++;
        if (bus.out !== it.val || bus.busy !== it.bsy) begin
          bad++;
          $display("FAIL %s: got out=%h busy=%b, want out=%h busy=%b",
                   it.name, bus.out, bus.busy, it.val, it.bsy);
        end
      end
    end
  end

  // Latency monitor: counts busy cycles and checks each busy pulse width.
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (bus.busy === 1'b1) begin
      busy_cnt++;
    end else if (busy_cnt > 0) begin
      total++;
      if (lat_q.size() == 0) begin
        bad++;
        $display("FAIL busy_pulse: got unexpected busy pulse of %0d cycles, want none", busy_cnt);
      end else begin
        int exp_lat;
        exp_lat = lat_q.pop_front();
        if (busy_cnt != exp_lat) begin
          bad++;
          $display("FAIL busy_len: got %0d cycles, want %0d", busy_cnt, exp_lat);
        end
      end
      busy_cnt = 0;
    end
  end

  always @(posedge clk) begin
    if (bus.start === 1'b1 && bus.busy === 1'b1) begin
      bad++;
      $display("FAIL start_in_run: got start=1 while busy=1, want start=0");
    end
  end

  task automatic check(input string nm, input logic sel, input logic [31:0] v, input logic b);
    item_t it;
    bus.out_sel = sel;
    it.name = nm;
    it.sel  = sel;
    it.val  = v;
    it.bsy  = b;
    sb_q.push_back(it);
    ->chk_ev;
    #2;
  endtask

  // Called at a falling edge; holds the request across one rising edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic fl);
    bus.start = 1'b1;
    bus.op    = o;
    bus.rs    = a;
    bus.rt    = b;
    bus.flush = fl;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 4'd0;
    bus.flush = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) begin
      total++;
      bad++;
      $display("FAIL wait_idle: got busy still high after %0d cycles, want low", lim);
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 4'd0;
    bus.rs      = 32'd0;
    bus.rt      = 32'd0;
    bus.out_sel = 1'b0;
    bus.flush   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset_hi", 1'b0, 32'h0, 1'b0);
    check("reset_lo", 1'b1, 32'h0, 1'b0);
    @(negedge clk);

`ifdef MDU_FAST_EN
    issue(MDU_MULT, 32'd3, 32'd4, 1'b0);
    check("fast_mult_lo", 1'b1, 32'd12, 1'b0);
    check("fast_mult_hi", 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    issue(MDU_DIV, 32'd100, 32'd7, 1'b0);
    check("fast_div_lo", 1'b1, 32'd14, 1'b0);
    check("fast_div_hi", 1'b0, 32'd2, 1'b0);
    @(negedge clk);
`else
    lat_q.push_back(5);
    issue(MDU_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("mult_midrun_hi", 1'b0, 32'h0, 1'b1);
    wait_idle(20);
    check("mult_hi", 1'b0, 32'hFFFF_FFFF, 1'b0);
    check("mult_lo", 1'b1, 32'hFFFF_FFFE, 1'b0);
    @(negedge clk);

    lat_q.push_back(5);
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle(20);
    check("multu_hi", 1'b0, 32'h0000_0001, 1'b0);
    check("multu_lo", 1'b1, 32'hFFFF_FFFE, 1'b0);
    @(negedge clk);

    lat_q.push_back(5);
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd4, 1'b0);
    wait_idle(20);
    check("mult_neg_hi", 1'b0, 32'hFFFF_FFFF, 1'b0);
    check("mult_neg_lo", 1'b1, 32'hFFFF_FFF4, 1'b0);
    @(negedge clk);

    lat_q.push_back(10);
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(30);
    check("div_lo", 1'b1, 32'hFFFF_FFFD, 1'b0);
    check("div_hi", 1'b0, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);

    lat_q.push_back(10);
    issue(MDU_DIVU, 32'd7, 32'd0, 1'b0);
    wait_idle(30);
    check("divu0_lo", 1'b1, 32'hFFFF_FFFD, 1'b0);
    check("divu0_hi", 1'b0, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);

    issue(MDU_MTHI, 32'h0000_1234, 32'd0, 1'b0);
    check("mthi_hi", 1'b0, 32'h0000_1234, 1'b0);
    issue(MDU_MTLO, 32'h0000_5678, 32'd0, 1'b0);
    check("mtlo_lo", 1'b1, 32'h0000_5678, 1'b0);
    check("mtlo_hi_kept", 1'b0, 32'h0000_1234, 1'b0);
    @(negedge clk);

    issue(MDU_MULT, 32'd9, 32'd9, 1'b1);
    check("flush_start_hi", 1'b0, 32'h0000_1234, 1'b0);
    check("flush_start_lo", 1'b1, 32'h0000_5678, 1'b0);
    @(negedge clk);

    issue(4'd7, 32'd1, 32'd1, 1'b0);
    check("badop_hi", 1'b0, 32'h0000_1234, 1'b0);
    check("badop_lo", 1'b1, 32'h0000_5678, 1'b0);
    @(negedge clk);

    lat_q.push_back(10);
    issue(MDU_DIV, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    wait_idle(30);
    check("div_flushrun_lo", 1'b1, 32'd14, 1'b0);
    check("div_flushrun_hi", 1'b0, 32'd2, 1'b0);
    @(negedge clk);

    lat_q.push_back(2);
    issue(MDU_MULT, 32'd5, 32'd6, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_run_hi", 1'b0, 32'h0, 1'b0);
    check("rst_run_lo", 1'b1, 32'h0, 1'b0);
    repeat (12) @(negedge clk);
    check("rst_nolate_hi", 1'b0, 32'h0, 1'b0);
    check("rst_nolate_lo", 1'b1, 32'h0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    total++;
    if (lat_q.size() != 0) begin
      bad++;
      $display("FAIL busy_pulses_seen: got %0d expected pulses missing, want 0", lat_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, want finished");
    $fatal(1, "timeout");
  end

endmodule
